// File: rtl/fetch_requester.sv
// rtl/fetch_requester.sv - instruction-fetch initiator with in-order fetch buffer and redirect
module fetch_requester #(
    parameter logic [31:0] STARTING_ADDR = 32'h0100_0000,
    parameter int          DEPTH         = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    input  logic [31:0] mem_data_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        misaligned_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        pc;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [31:0]        buf_data [DEPTH];
    logic [31:0]        buf_pc   [DEPTH];

    logic redirect_take;
    logic pop;
    logic push;

    // A redirect outranks everything; HALT ignores redirects and pops; pushes
    // may use the slot freed by a same-edge pop when the buffer is full.
    always_comb begin
        redirect_take = redirect_valid && (state != HALT);
        pop  = inst_valid && inst_ready && !redirect_take && (state != HALT);
        push = (state == FETCH) && enable && !redirect_take &&
               ((count < FULL_COUNT) || pop);
    end

    // Control FSM, PC, pointers, occupancy and the sticky alignment error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pc             <= STARTING_ADDR;
            count          <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            misaligned_err <= 1'b0;
        end else if (redirect_take) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            if (redirect_pc[1:0] == 2'b00) begin
                pc    <= redirect_pc;
                state <= enable ? FETCH : IDLE;
            end else begin
                misaligned_err <= 1'b1;
                state          <= HALT;
            end
        end else begin
            case (state)
                IDLE:    if (enable) state <= FETCH;
                FETCH:   if (!enable) state <= IDLE;
                default: state <= HALT;
            endcase
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Buffer storage; contents are only observed through count, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            buf_data[wr_ptr] <= mem_data_out;
            buf_pc[wr_ptr]   <= pc;
        end
    end

    // Head presentation and the fixed read-only memory controls.
    always_comb begin
        inst_valid     = (count != '0);
        inst           = inst_valid ? buf_data[rd_ptr] : 32'd0;
        inst_pc        = inst_valid ? buf_pc[rd_ptr]   : 32'd0;
        mem_address    = pc;
        mem_data_in    = 32'd0;
        mem_read_write = 1'b0;
    end

endmodule

// File: tb/tb_fetch_requester.sv
// tb/tb_fetch_requester.sv - directed self-checking bench for fetch_requester
module tb_fetch_requester;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_write;
    logic [31:0] mem_data_out;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misaligned_err;

    int tests;
    int fails;

    fetch_requester #(
        .STARTING_ADDR(32'h0100_0000),
        .DEPTH(2)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .mem_address(mem_address),
        .mem_data_in(mem_data_in),
        .mem_read_write(mem_read_write),
        .mem_data_out(mem_data_out),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .misaligned_err(misaligned_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational memory image; unlisted addresses return the inverted address.
    always_comb begin
        case (mem_address)
            32'h0100_0000: mem_data_out = 32'h0000_0093;
            32'h0100_0004: mem_data_out = 32'h0010_0113;
            32'h0100_0008: mem_data_out = 32'h0020_0193;
            32'h0100_000C: mem_data_out = 32'h0030_0213;
            32'h0100_0010: mem_data_out = 32'h0040_0293;
            32'h0100_0014: mem_data_out = 32'h0050_0313;
            default:       mem_data_out = ~mem_address;
        endcase
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic en, input logic rdy);
        reset_n        = 1'b0;
        enable         = en;
        inst_ready     = rdy;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0);
        tests++;
        if ({inst_valid, inst, inst_pc, misaligned_err} !== {1'b1 ^ 1'b1, 32'd0, 32'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_outputs got v=%b i=%h pc=%h err=%b want 0/0/0/0",
                     inst_valid, inst, inst_pc, misaligned_err);
        end
        tests++;
        if ({mem_address, mem_data_in, mem_read_write} !== {32'h0100_0000, 32'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_mem got addr=%h din=%h rw=%b want 01000000/0/0",
                     mem_address, mem_data_in, mem_read_write);
        end
    endtask

    task automatic test_startup();
        do_reset(1'b1, 1'b1);
        step();
        tests++;
        if ({inst_valid, mem_address} !== {1'b0, 32'h0100_0000}) begin
            fails++;
            $display("FAIL startup_e0 got v=%b addr=%h want 0/01000000", inst_valid, mem_address);
        end
        step();
        tests++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0100_0000, 32'h0000_0093}) begin
            fails++;
            $display("FAIL startup_w0 got v=%b pc=%h i=%h want 1/01000000/00000093", inst_valid, inst_pc, inst);
        end
        step();
        tests++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0100_0004, 32'h0010_0113}) begin
            fails++;
            $display("FAIL startup_w1 got v=%b pc=%h i=%h want 1/01000004/00100113", inst_valid, inst_pc, inst);
        end
        step();
        tests++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0100_0008, 32'h0020_0193}) begin
            fails++;
            $display("FAIL startup_w2 got v=%b pc=%h i=%h want 1/01000008/00200193", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step();
        tests++;
        if ({inst_valid, inst_pc, inst, mem_address} !==
            {1'b1, 32'h0100_0000, 32'h0000_0093, 32'h0100_0008}) begin
            fails++;
            $display("FAIL bp_stall got v=%b pc=%h i=%h addr=%h want 1/01000000/00000093/01000008",
                     inst_valid, inst_pc, inst, mem_address);
        end
        inst_ready = 1'b1;
        step();
        tests++;
        if ({inst_pc, inst, mem_address} !== {32'h0100_0004, 32'h0010_0113, 32'h0100_000C}) begin
            fails++;
            $display("FAIL bp_full_pop1 got pc=%h i=%h addr=%h want 01000004/00100113/0100000c",
                     inst_pc, inst, mem_address);
        end
        step();
        tests++;
        if ({inst_pc, inst, mem_address} !== {32'h0100_0008, 32'h0020_0193, 32'h0100_0010}) begin
            fails++;
            $display("FAIL bp_full_pop2 got pc=%h i=%h addr=%h want 01000008/00200193/01000010",
                     inst_pc, inst, mem_address);
        end
        step();
        tests++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0100_000C, 32'h0030_0213}) begin
            fails++;
            $display("FAIL bp_full_pop3 got v=%b pc=%h i=%h want 1/0100000c/00300213", inst_valid, inst_pc, inst);
        end
        step();
        tests++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0100_0010, 32'h0040_0293}) begin
            fails++;
            $display("FAIL bp_full_pop4 got v=%b pc=%h i=%h want 1/01000010/00400293", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_enable_gate();
        do_reset(1'b1, 1'b0);
        step();
        step();
        enable = 1'b0;
        step();
        tests++;
        if ({inst_valid, inst_pc, mem_address} !== {1'b1, 32'h0100_0000, 32'h0100_0004}) begin
            fails++;
            $display("FAIL en_drop got v=%b pc=%h addr=%h want 1/01000000/01000004", inst_valid, inst_pc, mem_address);
        end
        enable = 1'b1;
        step();
        tests++;
        if (mem_address !== 32'h0100_0004) begin
            fails++;
            $display("FAIL en_idle_to_fetch got addr=%h want 01000004", mem_address);
        end
        step();
        tests++;
        if (mem_address !== 32'h0100_0008) begin
            fails++;
            $display("FAIL en_resume got addr=%h want 01000008", mem_address);
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1, 1'b0);
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0010;
        step();
        tests++;
        if ({inst_valid, inst, inst_pc, mem_address} !== {1'b0, 32'd0, 32'd0, 32'h0100_0010}) begin
            fails++;
            $display("FAIL redir_flush got v=%b i=%h pc=%h addr=%h want 0/0/0/01000010",
                     inst_valid, inst, inst_pc, mem_address);
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        step();
        tests++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0100_0010, 32'h0040_0293}) begin
            fails++;
            $display("FAIL redir_first got v=%b pc=%h i=%h want 1/01000010/00400293", inst_valid, inst_pc, inst);
        end
        step();
        tests++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0100_0014, 32'h0050_0313}) begin
            fails++;
            $display("FAIL redir_second got v=%b pc=%h i=%h want 1/01000014/00500313", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_misaligned();
        do_reset(1'b1, 1'b1);
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0006;
        step();
        tests++;
        if ({misaligned_err, inst_valid, mem_address} !== {1'b1, 1'b0, 32'h0100_0008}) begin
            fails++;
            $display("FAIL mis_enter got err=%b v=%b addr=%h want 1/0/01000008", misaligned_err, inst_valid, mem_address);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0020;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        tests++;
        if ({misaligned_err, inst_valid, mem_address} !== {1'b1, 1'b0, 32'h0100_0008}) begin
            fails++;
            $display("FAIL mis_halt got err=%b v=%b addr=%h want 1/0/01000008", misaligned_err, inst_valid, mem_address);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({misaligned_err, mem_address} !== {1'b0, 32'h0100_0000}) begin
            fails++;
            $display("FAIL mis_reset got err=%b addr=%h want 0/01000000", misaligned_err, mem_address);
        end
    endtask

    task automatic test_wrap_async_reset();
        do_reset(1'b1, 1'b0);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        tests++;
        if ({inst_valid, mem_address} !== {1'b0, 32'hFFFF_FFFC}) begin
            fails++;
            $display("FAIL wrap_redir got v=%b addr=%h want 0/fffffffc", inst_valid, mem_address);
        end
        step();
        tests++;
        if ({inst_valid, inst_pc, inst, mem_address} !== {1'b1, 32'hFFFF_FFFC, 32'h0000_0003, 32'h0000_0000}) begin
            fails++;
            $display("FAIL wrap_pc got v=%b pc=%h i=%h addr=%h want 1/fffffffc/00000003/00000000",
                     inst_valid, inst_pc, inst, mem_address);
        end
        step();
        tests++;
        if ({inst_pc, mem_address} !== {32'hFFFF_FFFC, 32'h0000_0004}) begin
            fails++;
            $display("FAIL wrap_full got pc=%h addr=%h want fffffffc/00000004", inst_pc, mem_address);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({inst_valid, inst, inst_pc, mem_address} !== {1'b0, 32'd0, 32'd0, 32'h0100_0000}) begin
            fails++;
            $display("FAIL async_reset got v=%b i=%h pc=%h addr=%h want 0/0/0/01000000",
                     inst_valid, inst, inst_pc, mem_address);
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        reset_n        = 1'b0;
        enable         = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        test_reset();
        test_startup();
        test_backpressure();
        test_enable_gate();
        test_redirect();
        test_misaligned();
        test_wrap_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_requester.md
# fetch_requester

Instruction-fetch initiator that drives the read side of `mainmem` from the processor's side. It holds the fetch PC and presents it as the memory address. Each returned word is captured into a small in-order buffer, tagged with its PC, and handed to decode over a valid/ready handshake. It supports a redirect (branch/jump target) that flushes buffered words and restarts fetch at a new address.

## Interface
- `STARTING_ADDR`, 'h01000000, PC value after reset; base of the memory image.
- `DEPTH`, 2, fetch buffer entries; power of two, ≥ 2.
- `clock`  in  1  single clock; all state changes on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  fetch permitted while high.
- `redirect_valid`  in  1  load `redirect_pc` into PC and flush the buffer.
- `redirect_pc`  in  32  new fetch address.
- `mem_address`  out  32  to `mainmem.address`; equals the PC register.
- `mem_data_in`  out  32  to `mainmem.data_in`; constant 0.
- `mem_read_write`  out  1  to `mainmem.read_write`; constant 0 (READ).
- `mem_data_out`  in  32  from `mainmem.data_out`; combinational read of `mem_address`.
- `inst_valid`  out  1  buffer head holds a word.
- `inst_ready`  in  1  decode accepts the head this cycle.
- `inst`  out  32  head word; 0 when empty.
- `inst_pc`  out  32  address of the head word; 0 when empty.
- `misaligned_err`  out  1  sticky; redirect to a non-word-aligned address.

## Operation
- **Reset** (`reset_n` = 0, immediate, any state) sets:
  - state IDLE; PC = `STARTING_ADDR`; buffer count 0;
  - `inst_valid` = 0, `inst` = 0, `inst_pc` = 0, `misaligned_err` = 0, `mem_address` = `STARTING_ADDR`.
- **States:**
  - IDLE: no capture. Moves to FETCH on a posedge with `enable` = 1.
  - FETCH: captures on a posedge when `enable` = 1 and (count < DEPTH, or a pop occurs on the same edge). A capture pushes {PC, `mem_data_out`} and sets PC ← PC + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000). Moves to IDLE on a posedge with `enable` = 0; no capture on that edge.
  - HALT: entered on a misaligned redirect. No capture and no state change until reset. The buffer stays empty and pops are ignored.
- **Pop:** at a posedge with `inst_valid` & `inst_ready`, the head is removed. The next entry (if any) becomes the head after the edge.
- **Simultaneous push and pop:**
  - When full, both are allowed and count stays at DEPTH.
  - When empty, pop is impossible; push only.
- **Redirect** (any state except HALT) has priority over push, pop and `enable` on that edge:
  - count ← 0, no capture, no pop.
  - If `redirect_pc[1:0]` = 0: PC ← `redirect_pc`, state ← FETCH if `enable` = 1, else IDLE.
  - Otherwise: PC unchanged, `misaligned_err` ← 1, state ← HALT.
- **Ordering:** the buffer is strictly in order; `inst_pc` values between redirects increase by exactly 4.
- **Outputs from state:** `inst_valid` = (count ≠ 0); `inst`/`inst_pc` come from the head entry.

## Timing
- `mem_address` is registered and changes only after a posedge, so memory has a full cycle to return `mem_data_out`.
- `mem_data_out` is sampled at the same posedge that advances PC.
- **Startup latency:**
  - `enable` is sampled high at edge E0 (IDLE→FETCH).
  - The first capture happens at E1.
  - `inst_valid` = 1 after E1 with `inst_pc` = `STARTING_ADDR`.
- **Steady state:** with `inst_ready` held high, one word per cycle.
- **Redirect latency:**
  - The redirect edge is R0; the buffer empties after R0.
  - The first new word is captured at R0+1 and visible after it, when `enable` = 1.
- **Backpressure:** with `inst_ready` = 0, capture stops after DEPTH words. PC then holds at (last captured PC + 4) with no lost or duplicated word.
- **Reset mid-operation:** all buffered words are discarded and no handshake completes on that edge.

## Test plan
- **Startup:** image words 0x00000093, 0x00100113, 0x00200193 at 0x01000000..08; `enable` = 1, `inst_ready` = 1 from reset release -> (`inst_pc`, `inst`) pairs are (0x01000000, 0x00000093), (0x01000004, 0x00100113), (0x01000008, 0x00200193) on consecutive cycles, first valid one edge after the E0 edge.
- **Backpressure:** `inst_ready` = 0 for 5 cycles after startup -> count saturates at 2, `mem_address` holds 0x01000008, and head stays 0x00000093. Releasing `inst_ready` gives the same sequence with no gaps, duplicates or loss.
- **Full with simultaneous pop:** buffer full, `inst_ready` = 1 -> push and pop on the same edge, count stays 2, throughput one per cycle.
- **Redirect:** `redirect_valid` = 1 with `redirect_pc` = 0x01000010 while 2 words are buffered -> `inst_valid` = 0 after that edge. The next `inst_pc` is 0x01000010, carrying the word at offset 0x10.
- **Misaligned redirect:** `redirect_pc` = 0x01000006 -> `misaligned_err` = 1, state HALT, `inst_valid` stays 0 and `mem_address` frozen until `reset_n` low. After reset: `misaligned_err` = 0 and `mem_address` = 0x01000000.
- **Wrap and async reset:** redirect to 0xFFFFFFFC -> next `mem_address` is 0x00000000. Asserting `reset_n` = 0 mid-cycle with a full buffer clears `inst_valid` immediately, without waiting for a clock edge.
